// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI NOR flash reader.
package spi_flash_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StCsSetup,
    StCmd,
    StAddr,
    StDummy,
    StData,
    StStall,
    StCsHold,
    StDone
  } state_e;

  localparam logic [7:0]  CMD_READ      = 8'h03;
  localparam logic [7:0]  CMD_FAST_READ = 8'h0B;
  localparam int unsigned DUMMY_CYCLES  = 8;
  localparam int unsigned ADDR_BITS     = 24;

endpackage

// File: rtl/spi_sck_gen.sv
// SPI clock generator: divides CLK by 2*CLK_DIV while enabled. pause_i suppresses
// rising edges only, so a high SCK always completes its half-period and parks low.
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic pause_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o,
  output logic tick_o
);

  localparam int unsigned CntW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sck_q, sck_d;

  assign tick_o = en_i && (cnt_q == CntMax);
  assign rise_o = tick_o && !sck_q && !pause_i;
  assign fall_o = tick_o && sck_q;
  assign sck_o  = sck_q;

  // Half-period counter and SCK level; disabled means counter cleared and SCK low.
  always_comb begin
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (!en_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
      if (rise_o || fall_o) sck_d = !sck_q;
    end
  end

  // Counter and SCK registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// Single-bit SPI NOR READ streamer: address + length in, bytes out on valid/ready.
// Build option SPI_FAST_READ_EN selects FAST_READ (0x0B) with 8 dummy clocks.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned LEN_W   = 16
) (
  input  logic                 CLK,
  input  logic                 RESETN,
  input  logic                 start_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [LEN_W-1:0]     len_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [7:0]           data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 sck_o,
  output logic                 cs_n_o,
  output logic                 mosi_o,
  input  logic                 miso_i,
  output logic                 wp_n_o,
  output logic                 hold_n_o
);

`ifdef SPI_FAST_READ_EN
  localparam logic [7:0] ReadCmd  = CMD_FAST_READ;
  localparam bit         HasDummy = 1'b1;
`else
  localparam logic [7:0] ReadCmd  = CMD_READ;
  localparam bit         HasDummy = 1'b0;
`endif

  localparam logic [4:0] ByteLast  = 5'd7;
  localparam logic [4:0] AddrLast  = 5'(ADDR_BITS - 1);
  localparam logic [4:0] DummyLast = 5'(DUMMY_CYCLES - 1);

  state_e                     state_q, state_d;
  logic [ADDR_BITS+7:0]       sh_q, sh_d;
  logic [7:0]                 rx_q, rx_d;
  logic [4:0]                 bit_q, bit_d;
  logic [LEN_W-1:0]           byte_q, byte_d;
  logic [7:0]                 data_q, data_d;
  logic                       valid_q, valid_d;

  logic sck_en, sck_pause, sck, sck_rise, sck_fall, sck_tick;
  logic [4:0] seg_last;
  logic seg_end, blocked;

  spi_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck_gen (
    .clk_i  (CLK),
    .rst_ni (RESETN),
    .en_i   (sck_en),
    .pause_i(sck_pause),
    .sck_o  (sck),
    .rise_o (sck_rise),
    .fall_o (sck_fall),
    .tick_o (sck_tick)
  );

  // A completed byte cannot land while the output register is still held.
  assign blocked = valid_q && !ready_i;

  // Last bit index of the current serial segment.
  always_comb begin
    case (state_q)
      StAddr:  seg_last = AddrLast;
      StDummy: seg_last = DummyLast;
      default: seg_last = ByteLast;
    endcase
  end
  assign seg_end = (bit_q == seg_last);

  // State register.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) state_q <= StIdle;
    else         state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (start_i) state_d = (len_i != '0) ? StCsSetup : StDone;
      StCsSetup: if (sck_tick) state_d = StCmd;
      StCmd:     if (sck_rise && seg_end) state_d = StAddr;
      StAddr:    if (sck_rise && seg_end) state_d = HasDummy ? StDummy : StData;
      StDummy:   if (sck_rise && seg_end) state_d = StData;
      StData: begin
        // Zero bytes left: wait for SCK to return low, then hold CS.
        if (byte_q == '0) begin
          if (sck_fall) state_d = StCsHold;
        end else if (bit_q == ByteLast && blocked) begin
          state_d = StStall;
        end
      end
      StStall:   if (!blocked) state_d = StData;
      StCsHold:  if (sck_tick && bit_q == 5'd1) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  // Moore outputs and SCK generator control.
  always_comb begin
    cs_n_o    = 1'b1;
    sck_en    = 1'b0;
    sck_pause = 1'b0;
    mosi_o    = 1'b0;
    busy_o    = (state_q != StIdle);
    done_o    = (state_q == StDone);
    case (state_q)
      StCsSetup: begin
        cs_n_o    = 1'b0;
        sck_en    = 1'b1;
        sck_pause = 1'b1;
        mosi_o    = sh_q[ADDR_BITS+7];
      end
      StCmd, StAddr: begin
        cs_n_o = 1'b0;
        sck_en = 1'b1;
        mosi_o = sh_q[ADDR_BITS+7];
      end
      StDummy: begin
        cs_n_o = 1'b0;
        sck_en = 1'b1;
      end
      StData: begin
        cs_n_o    = 1'b0;
        sck_en    = 1'b1;
        sck_pause = (byte_q == '0) || (bit_q == ByteLast && blocked);
      end
      StStall, StCsHold: begin
        cs_n_o    = 1'b0;
        sck_en    = 1'b1;
        sck_pause = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath next state: shift registers, counters and the output register.
  always_comb begin
    sh_d    = sh_q;
    rx_d    = rx_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && ready_i) valid_d = 1'b0;
    if (state_q == StIdle && start_i && len_i != '0) begin
      sh_d   = {ReadCmd, addr_i};
      byte_d = len_i;
      bit_d  = '0;
    end
    // MOSI advances on falling SCK.
    if ((state_q == StCmd || state_q == StAddr) && sck_fall) begin
      sh_d = {sh_q[ADDR_BITS+6:0], 1'b0};
    end
    if (sck_rise) bit_d = seg_end ? '0 : bit_q + 1'b1;
    if (state_q == StData && sck_rise) begin
      rx_d = {rx_q[6:0], miso_i};
      if (seg_end) begin
        data_d  = {rx_q[6:0], miso_i};
        valid_d = 1'b1;
        byte_d  = byte_q - 1'b1;
      end
    end
    // CS hold time counted in SCK half-periods.
    if (state_q == StCsHold && sck_tick) bit_d = bit_q + 1'b1;
  end

  // Datapath registers.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      sh_q    <= '0;
      rx_q    <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign sck_o    = sck;
  assign data_o   = data_q;
  assign valid_o  = valid_q;
  assign wp_n_o   = 1'b1;
  assign hold_n_o = 1'b1;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Directed bench for spi_flash_reader with a behavioural SPI NOR flash model.
// Flash content: byte at address a = a[7:0] ^ a[15:8] ^ 8'h5A.
module tb_spi_flash_reader;

`ifdef SPI_FAST_READ_EN
  localparam int unsigned Div     = 3;
  localparam int          HdrBits = 40;
  localparam logic [7:0]  ExpCmd  = 8'h0B;
`else
  localparam int unsigned Div     = 1;
  localparam int          HdrBits = 32;
  localparam logic [7:0]  ExpCmd  = 8'h03;
`endif
  localparam int Budget = 3000 * Div;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        start_i = 1'b0;
  logic [23:0] addr_i = '0;
  logic [15:0] len_i = '0;
  logic        ready_i = 1'b1;
  logic        miso_i = 1'b0;
  logic        busy_o, done_o, valid_o, sck_o, cs_n_o, mosi_o, wp_n_o, hold_n_o;
  logic [7:0]  data_o;

  int          n_chk = 0;
  int          n_err = 0;
  logic [7:0]  rx_q[$];
  int          done_cnt = 0;
  bit          cs_low_seen = 1'b0;
  int          nrise = 0;
  logic [31:0] hdr = '0;
  int          dummy_ones = 0;
  longint      t_last = 0;
  longint      sck_per = 0;

  spi_flash_reader #(
    .CLK_DIV(Div),
    .LEN_W  (16)
  ) dut (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .start_i (start_i),
    .addr_i  (addr_i),
    .len_i   (len_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .data_o  (data_o),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .sck_o   (sck_o),
    .cs_n_o  (cs_n_o),
    .mosi_o  (mosi_o),
    .miso_i  (miso_i),
    .wp_n_o  (wp_n_o),
    .hold_n_o(hold_n_o)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Consumer side and pin monitors, sampled mid-cycle.
  always @(negedge CLK) begin
    if (valid_o && ready_i) rx_q.push_back(data_o);
    if (done_o) done_cnt++;
    if (!cs_n_o) cs_low_seen = 1'b1;
  end

  // Flash model: new command on CS fall, shift header on SCK rise, drive data on SCK fall.
  always @(negedge cs_n_o) begin
    nrise  = 0;
    t_last = 0;
  end

  always @(posedge sck_o) begin
    if (!cs_n_o) begin
      if (nrise < 32) hdr = {hdr[30:0], mosi_o};
      else if (nrise < HdrBits) dummy_ones += int'(mosi_o);
      nrise++;
      if (t_last != 0) sck_per = $time - t_last;
      t_last = $time;
    end
  end

  always @(negedge sck_o) begin
    int         k;
    logic [7:0] b;
    if (!cs_n_o && nrise >= HdrBits) begin
      k      = nrise - HdrBits;
      b      = mem_byte(hdr[23:0] + 24'(k / 8));
      miso_i = b[7 - (k % 8)];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic launch(input logic [23:0] a, input logic [15:0] l);
    @(posedge CLK);
    #1;
    start_i = 1'b1;
    addr_i  = a;
    len_i   = l;
    @(posedge CLK);
    #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done();
    int base;
    base = done_cnt;
    for (int i = 0; i < Budget && done_cnt == base; i++) @(negedge CLK);
    check("done_seen", 32'(done_cnt != base), 32'd1);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3, input int n);
    logic [7:0] exp [4];
    exp = '{e0, e1, e2, e3};
    check({tag, "_count"}, 32'(rx_q.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_byte%0d", tag, i),
            (i < rx_q.size()) ? {24'h0, rx_q[i]} : 32'hFFFF_FFFF, {24'h0, exp[i]});
    end
  endtask

  initial begin
    int idle_bad;
    int sck_hi;

    // Reset values.
    #12;
    check("rst_cs_n", cs_n_o, 1);
    check("rst_sck", sck_o, 0);
    check("rst_mosi", mosi_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_data", data_o, 0);
    check("rst_wp_n", wp_n_o, 1);
    check("rst_hold_n", hold_n_o, 1);
    cycles(2);
    RESETN = 1'b1;
    idle_bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (cs_n_o !== 1'b1 || sck_o !== 1'b0 || busy_o !== 1'b0 ||
          wp_n_o !== 1'b1 || hold_n_o !== 1'b1) idle_bad++;
    end
    check("idle_100", idle_bad, 0);

    // Plain 4-byte read; a second start while busy must be ignored.
    rx_q.delete();
    done_cnt = 0;
    launch(24'h000100, 16'd4);
    check("busy_after_start", busy_o, 1);
    cycles(10);
    launch(24'h005000, 16'd9);
    wait_done();
    cycles(3);
    check("hdr_read", hdr, {ExpCmd, 24'h000100});
    check_bytes("read4", 8'h5B, 8'h5A, 8'h59, 8'h58, 4);
    check("read4_done_once", done_cnt, 1);
    check("read4_busy_end", busy_o, 0);
    check("read4_cs_end", cs_n_o, 1);

    // Backpressure after the first byte.
    rx_q.delete();
    done_cnt = 0;
    launch(24'h000100, 16'd4);
    for (int i = 0; i < Budget && rx_q.size() < 1; i++) @(negedge CLK);
    @(posedge CLK);
    #1;
    ready_i = 1'b0;
    sck_hi  = 0;
    for (int i = 0; i < 50 * Div; i++) begin
      @(negedge CLK);
      if (i >= 40 * Div && sck_o !== 1'b0) sck_hi++;
    end
    check("stall_sck_low", sck_hi, 0);
    check("stall_cs_low", cs_n_o, 0);
    check("stall_valid", valid_o, 1);
    check("stall_data", data_o, 8'h5A);
    check("stall_beats", 32'(rx_q.size()), 1);
    @(posedge CLK);
    #1;
    ready_i = 1'b1;
    wait_done();
    cycles(3);
    check_bytes("stall", 8'h5B, 8'h5A, 8'h59, 8'h58, 4);
    check("stall_done_once", done_cnt, 1);

    // Zero-length request.
    done_cnt    = 0;
    cs_low_seen = 1'b0;
    launch(24'h000300, 16'd0);
    check("len0_busy", busy_o, 1);
    check("len0_done", done_o, 1);
    cycles(1);
    check("len0_busy_drop", busy_o, 0);
    check("len0_done_drop", done_o, 0);
    cycles(5);
    check("len0_cs_never_low", 32'(cs_low_seen), 0);
    check("len0_done_once", done_cnt, 1);

    // Reset in the middle of the address phase.
    launch(24'h000100, 16'd4);
    for (int i = 0; i < Budget && nrise < 12; i++) @(negedge CLK);
    check("reached_addr", 32'(nrise >= 12), 1);
    @(posedge CLK);
    #2;
    RESETN = 1'b0;
    #1;
    check("midrst_cs_n", cs_n_o, 1);
    check("midrst_sck", sck_o, 0);
    check("midrst_busy", busy_o, 0);
    cycles(3);
    RESETN = 1'b1;
    cycles(3);
    rx_q.delete();
    done_cnt = 0;
    launch(24'h000200, 16'd2);
    wait_done();
    cycles(3);
    check("hdr_after_rst", hdr, {ExpCmd, 24'h000200});
    check_bytes("after_rst", 8'h58, 8'h59, 8'h00, 8'h00, 2);
    check("sck_period", 32'(sck_per), 32'(2 * Div * 10));
`ifdef SPI_FAST_READ_EN
    check("dummy_mosi_zero", dummy_ones, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
